// File: rtl/nios_with_onchip_sdram_onchip_memory_arbiter.sv
// Round-robin arbiter sharing the single-port on-chip RAM between the Nios data master (m0)
// and a DMA master (m1), with read-return routing, OOR protection and optional post-reset scrub.
module nios_with_onchip_sdram_onchip_memory_arbiter #(
   parameter int ADDR_W    = 14,
   parameter int DATA_W    = 32,
   parameter int BE_W      = 4,
   parameter int NUM_WORDS = 12288,
   parameter int SCRUB_EN  = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata,
   output logic              busy,
   output logic              oor_err,
   input  logic              oor_err_clr
);

   typedef enum logic {ST_SCRUB, ST_RUN} state_t;

   localparam state_t            RESET_STATE = (SCRUB_EN != 0) ? ST_SCRUB : ST_RUN;
   localparam logic [ADDR_W:0]   DEPTH       = (ADDR_W+1)'(NUM_WORDS);
   localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_WORDS - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] scrub_addr_q, scrub_addr_d;
   logic              last_q, last_d;
   logic              rd_pend_q, rd_pend_d;
   logic              rd_owner_q, rd_owner_d;
   logic              rd_oor_q, rd_oor_d;
   logic              oor_err_q, oor_err_d;

   logic              run, scrub;
   logic [1:0]        req, gnt, rd_in, wr_in, wait_o, rvalid_o;
   logic [ADDR_W-1:0] addr_in  [2];
   logic [BE_W-1:0]   be_in    [2];
   logic [DATA_W-1:0] wdata_in [2];
   logic [DATA_W-1:0] rdata_o  [2];

   logic              gnt_any, sel, g_read, g_write, g_in_range, rd_acc, err_set;
   logic [ADDR_W-1:0] g_addr;
   logic [BE_W-1:0]   g_be;
   logic [DATA_W-1:0] g_wdata;

   // reset_n gates the outputs directly so reset values appear without waiting for a clock
   assign run   = reset_n & (state_q == ST_RUN);
   assign scrub = reset_n & (state_q == ST_SCRUB);

   assign rd_in       = {m1_read, m0_read};
   assign wr_in       = {m1_write, m0_write};
   assign addr_in[0]  = m0_address;
   assign addr_in[1]  = m1_address;
   assign be_in[0]    = m0_byteenable;
   assign be_in[1]    = m1_byteenable;
   assign wdata_in[0] = m0_writedata;
   assign wdata_in[1] = m1_writedata;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_master
         assign req[gi] = rd_in[gi] | wr_in[gi];
         // with both requesting, the master that was not granted last wins
         assign gnt[gi] = run & req[gi] & (~req[1-gi] | (last_q != 1'(gi)));
         assign wait_o[gi]   = ~run | (req[gi] & ~gnt[gi]);
         assign rvalid_o[gi] = rd_pend_q & (rd_owner_q == 1'(gi));
         assign rdata_o[gi]  = (rvalid_o[gi] & ~rd_oor_q) ? mem_readdata : '0;
      end
   endgenerate

   assign gnt_any    = |gnt;
   assign sel        = gnt[1];
   assign g_addr     = addr_in[sel];
   assign g_be       = be_in[sel];
   assign g_wdata    = wdata_in[sel];
   assign g_read     = rd_in[sel];
   assign g_write    = wr_in[sel];
   assign g_in_range = {1'b0, g_addr} < DEPTH;

   // a simultaneous read+write performs only the write
   assign rd_acc  = gnt_any & g_read & ~g_write;
   assign err_set = gnt_any & (~g_in_range | (g_read & g_write));

   assign m0_waitrequest   = wait_o[0];
   assign m1_waitrequest   = wait_o[1];
   assign m0_readdatavalid = rvalid_o[0];
   assign m1_readdatavalid = rvalid_o[1];
   assign m0_readdata      = rdata_o[0];
   assign m1_readdata      = rdata_o[1];

   assign mem_address    = scrub ? scrub_addr_q : g_addr;
   assign mem_byteenable = scrub ? '1 : g_be;
   assign mem_writedata  = scrub ? '0 : g_wdata;
   assign mem_chipselect = scrub | (gnt_any & g_in_range);
   assign mem_write      = scrub | (gnt_any & g_write);
   assign mem_clken      = reset_n;

   assign busy    = ~run;
   assign oor_err = oor_err_q;

   always_comb begin
      state_d      = state_q;
      scrub_addr_d = scrub_addr_q;
      last_d       = last_q;
      rd_pend_d    = rd_acc;
      rd_owner_d   = rd_owner_q;
      rd_oor_d     = rd_oor_q;
      oor_err_d    = err_set | (oor_err_q & ~oor_err_clr);
      if (state_q == ST_SCRUB) begin
         if (scrub_addr_q == LAST_ADDR) begin
            state_d      = ST_RUN;
            scrub_addr_d = '0;
         end else begin
            scrub_addr_d = scrub_addr_q + ADDR_W'(1);
         end
      end
      if (gnt_any) begin
         last_d = sel;
      end
      if (rd_acc) begin
         rd_owner_d = sel;
         rd_oor_d   = ~g_in_range;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= RESET_STATE;
         scrub_addr_q <= '0;
         last_q       <= 1'b1;
         rd_pend_q    <= 1'b0;
         rd_owner_q   <= 1'b0;
         rd_oor_q     <= 1'b0;
         oor_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         scrub_addr_q <= scrub_addr_d;
         last_q       <= last_d;
         rd_pend_q    <= rd_pend_d;
         rd_owner_q   <= rd_owner_d;
         rd_oor_q     <= rd_oor_d;
         oor_err_q    <= oor_err_d;
      end
   end

endmodule

// File: tb/tb_nios_with_onchip_sdram_onchip_memory_arbiter.sv
// Bench: behavioural RAM plus a command-queue reference model of the two-master arbiter.
module tb_nios_with_onchip_sdram_onchip_memory_arbiter;
   localparam int ADDR_W = 14, DATA_W = 32, BE_W = 4, NUM_WORDS = 12288;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset_n;
   logic [ADDR_W-1:0] m0_address, m1_address, mem_address;
   logic [BE_W-1:0]   m0_byteenable, m1_byteenable, mem_byteenable;
   logic              m0_read, m0_write, m1_read, m1_write;
   logic [DATA_W-1:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata;
   logic              m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
   logic              mem_chipselect, mem_write, mem_clken, busy, oor_err, oor_err_clr;
   logic [DATA_W-1:0] mem_writedata, mem_readdata;

   nios_with_onchip_sdram_onchip_memory_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .NUM_WORDS(NUM_WORDS), .SCRUB_EN(1)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
      .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
      .mem_readdata(mem_readdata), .busy(busy), .oor_err(oor_err), .oor_err_clr(oor_err_clr)
   );

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // on-chip RAM stand-in: registered read, byte-lane writes, gated by clken/chipselect
   logic [31:0] env_mem [NUM_WORDS];
   always @(posedge clk) begin
      if (mem_clken && mem_chipselect && int'(mem_address) < NUM_WORDS) begin
         if (mem_write) env_mem[mem_address] <= merge(env_mem[mem_address], mem_writedata, mem_byteenable);
         else           mem_readdata <= env_mem[mem_address];
      end
   end

   typedef struct {bit rd; bit wr; logic [13:0] addr; logic [3:0] be; logic [31:0] data;} cmd_t;
   cmd_t q0[$], q1[$];
   bit   clr_q[$];

   // reference model state
   logic [31:0] ref_mem [NUM_WORDS];
   int          scrub_left;
   bit          m_last, m_err, pend_v, pend_owner;
   logic [31:0] pend_data;
   int          cur_g;
   int          n_cmp, n_bad;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic cmd_t mk(bit rd, bit wr, int a, logic [3:0] be, logic [31:0] d);
      cmd_t c;
      c.rd = rd; c.wr = wr; c.addr = 14'(a); c.be = be; c.data = d;
      return c;
   endfunction

   function automatic cmd_t rand_cmd();
      int          k  = $urandom_range(0, 15);
      int          a  = $urandom_range(0, 31);
      int          oa = $urandom_range(NUM_WORDS, 16383);
      logic [3:0]  be = 4'($urandom);
      logic [31:0] d  = $urandom;
      if (k < 4)       return mk(0, 0, a, be, d);
      else if (k < 9)  return mk(1, 0, a, be, d);
      else if (k < 13) return mk(0, 1, a, be, d);
      else if (k == 13) return mk(1, 1, a, be, d);
      else if (k == 14) return mk(1, 0, oa, be, d);
      return mk(0, 1, oa, be, d);
   endfunction

   task automatic drive_inputs();
      m0_address = 14'($urandom); m0_byteenable = 4'($urandom); m0_writedata = $urandom;
      m1_address = 14'($urandom); m1_byteenable = 4'($urandom); m1_writedata = $urandom;
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0; oor_err_clr = 0;
      if (scrub_left > 0) begin
         m0_read = 1'($urandom); m0_write = 1'($urandom);
         m1_read = 1'($urandom); m1_write = 1'($urandom);
      end else begin
         if (q0.size() > 0) begin
            m0_read = q0[0].rd; m0_write = q0[0].wr; m0_address = q0[0].addr;
            m0_byteenable = q0[0].be; m0_writedata = q0[0].data;
         end
         if (q1.size() > 0) begin
            m1_read = q1[0].rd; m1_write = q1[0].wr; m1_address = q1[0].addr;
            m1_byteenable = q1[0].be; m1_writedata = q1[0].data;
         end
         if (clr_q.size() > 0) oor_err_clr = clr_q[0];
      end
   endtask

   task automatic check_outputs();
      bit req0, req1, gwr, inr;
      logic [13:0] ga; logic [3:0] gbe; logic [31:0] gwd;
      check("clken", mem_clken, 1);
      check("rvalid0", m0_readdatavalid, pend_v && !pend_owner);
      check("rvalid1", m1_readdatavalid, pend_v && pend_owner);
      check("rdata0", m0_readdata, (pend_v && !pend_owner) ? pend_data : 32'h0);
      check("rdata1", m1_readdata, (pend_v && pend_owner) ? pend_data : 32'h0);
      check("oor_err", oor_err, m_err);
      cur_g = -1;
      if (scrub_left > 0) begin
         check("busy", busy, 1);
         check("wait0", m0_waitrequest, 1);
         check("wait1", m1_waitrequest, 1);
         check("scrub_cs", mem_chipselect, 1);
         check("scrub_wr", mem_write, 1);
         check("scrub_addr", mem_address, NUM_WORDS - scrub_left);
         check("scrub_be", mem_byteenable, 4'hF);
         check("scrub_wd", mem_writedata, 0);
      end else begin
         req0 = m0_read || m0_write;
         req1 = m1_read || m1_write;
         if (req0 && req1) cur_g = (m_last == 0) ? 1 : 0;
         else if (req0)    cur_g = 0;
         else if (req1)    cur_g = 1;
         check("busy", busy, 0);
         check("wait0", m0_waitrequest, req0 && cur_g != 0);
         check("wait1", m1_waitrequest, req1 && cur_g != 1);
         ga = (cur_g == 1) ? m1_address : m0_address;
         gbe = (cur_g == 1) ? m1_byteenable : m0_byteenable;
         gwd = (cur_g == 1) ? m1_writedata : m0_writedata;
         gwr = (cur_g == 1) ? m1_write : m0_write;
         inr = int'(ga) < NUM_WORDS;
         check("cs", mem_chipselect, cur_g >= 0 && inr);
         check("mem_write", mem_write, cur_g >= 0 && gwr);
         if (cur_g >= 0 && inr) begin
            check("mem_addr", mem_address, ga);
            check("mem_be", mem_byteenable, gbe);
            if (gwr) check("mem_wd", mem_writedata, gwd);
         end
      end
   endtask

   task automatic model_update();
      bit newerr = 0;
      bit rd, wr, inr;
      logic [13:0] a; logic [3:0] be; logic [31:0] d;
      pend_v = 0;
      if (scrub_left > 0) begin
         scrub_left--;
         if (scrub_left == 0) for (int i = 0; i < NUM_WORDS; i++) ref_mem[i] = 32'h0;
         return;
      end
      if (cur_g >= 0) begin
         rd = (cur_g == 1) ? m1_read : m0_read;
         wr = (cur_g == 1) ? m1_write : m0_write;
         a  = (cur_g == 1) ? m1_address : m0_address;
         be = (cur_g == 1) ? m1_byteenable : m0_byteenable;
         d  = (cur_g == 1) ? m1_writedata : m0_writedata;
         inr = int'(a) < NUM_WORDS;
         m_last = (cur_g == 1);
         if (wr && inr) ref_mem[a] = merge(ref_mem[a], d, be);
         if (rd && !wr) begin
            pend_v = 1; pend_owner = (cur_g == 1); pend_data = inr ? ref_mem[a] : 32'h0;
         end
         newerr = !inr || (rd && wr);
         $display("txn m%0d rd=%0d wr=%0d addr=%0d be=%h data=%h", cur_g, rd, wr, a, be, d);
         if (cur_g == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      if (cur_g != 0 && q0.size() > 0 && !q0[0].rd && !q0[0].wr) void'(q0.pop_front());
      if (cur_g != 1 && q1.size() > 0 && !q1[0].rd && !q1[0].wr) void'(q1.pop_front());
      m_err = newerr ? 1'b1 : (oor_err_clr ? 1'b0 : m_err);
      if (clr_q.size() > 0) void'(clr_q.pop_front());
   endtask

   task automatic tick();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_update();
      #1;
      drive_inputs();
   endtask

   task automatic drain(input int budget);
      int n = 0;
      drive_inputs();
      while ((q0.size() > 0 || q1.size() > 0 || clr_q.size() > 0) && n < budget) begin
         tick();
         n++;
      end
      check("drain_timeout", q0.size() + q1.size() + clr_q.size(), 0);
      tick();
      tick();
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_wait0"}, m0_waitrequest, 1);
      check({tag, "_wait1"}, m1_waitrequest, 1);
      check({tag, "_rv0"}, m0_readdatavalid, 0);
      check({tag, "_rv1"}, m1_readdatavalid, 0);
      check({tag, "_rd0"}, m0_readdata, 0);
      check({tag, "_rd1"}, m1_readdata, 0);
      check({tag, "_cs"}, mem_chipselect, 0);
      check({tag, "_wr"}, mem_write, 0);
      check({tag, "_clken"}, mem_clken, 0);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_oor"}, oor_err, 0);
   endtask

   // async assert mid-cycle, hold two edges, release; model restarts the scrub count
   task automatic pulse_reset(input string tag);
      reset_n = 0;
      #1;
      m_err = 0; m_last = 1; pend_v = 0;
      q0.delete(); q1.delete(); clr_q.delete();
      check_reset(tag);
      repeat (2) @(posedge clk);
      #1;
      check_reset({tag, "_held"});
      reset_n = 1;
      scrub_left = NUM_WORDS;
      drive_inputs();
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      for (int i = 0; i < NUM_WORDS; i++) env_mem[i] <= $urandom;
      reset_n = 0; oor_err_clr = 0;
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
      m0_address = 0; m1_address = 0; m0_byteenable = 0; m1_byteenable = 0;
      m0_writedata = 0; m1_writedata = 0;
      #12;
      check_reset("por");
      @(posedge clk); #1;
      reset_n = 1;
      scrub_left = NUM_WORDS; m_last = 1; m_err = 0; pend_v = 0;
      drive_inputs();
      while (scrub_left > 0) tick();

      // both masters streaming reads: grants alternate, m0 first
      for (int i = 0; i < 8; i++) begin
         q0.push_back(mk(1, 0, 10, 4'hF, 0));
         q1.push_back(mk(1, 0, 20, 4'hF, 0));
      end
      drain(100);
      q0.push_back(mk(1, 0, 5, 4'hF, 0));
      drain(20);
      q0.push_back(mk(0, 1, 10, 4'hF, 32'h1111_0010));
      q1.push_back(mk(0, 1, 20, 4'hF, 32'h2222_0020));
      for (int i = 0; i < 6; i++) begin
         q0.push_back(mk(1, 0, 10, 4'hF, 0));
         q1.push_back(mk(1, 0, 20, 4'hF, 0));
      end
      drain(100);

      // partial write by m1 then immediate read-back by m0
      q0.push_back(mk(0, 1, 7, 4'hF, 32'hDEAD_BEEF));
      q0.push_back(mk(0, 0, 0, 4'h0, 0));
      q0.push_back(mk(1, 0, 7, 4'hF, 0));
      q1.push_back(mk(0, 0, 0, 4'h0, 0));
      q1.push_back(mk(0, 1, 7, 4'b0011, 32'hA5A5_1234));
      drain(20);

      // out-of-range read, then error clear
      q0.push_back(mk(1, 0, 12300, 4'hF, 0));
      clr_q.push_back(0); clr_q.push_back(0); clr_q.push_back(0); clr_q.push_back(1);
      drain(20);

      // read and write together
      q0.push_back(mk(1, 1, 3, 4'hF, 32'h1));
      q0.push_back(mk(0, 0, 0, 4'h0, 0));
      q0.push_back(mk(1, 0, 3, 4'hF, 0));
      drain(20);

      for (int i = 0; i < 2000; i++) begin
         if (q0.size() < 2) q0.push_back(rand_cmd());
         if (q1.size() < 2) q1.push_back(rand_cmd());
         clr_q.push_back($urandom_range(0, 15) == 0);
         if (i == 0) drive_inputs();
         tick();
      end
      drain(200);

      // reset with a read in flight
      q0.push_back(mk(1, 0, 10, 4'hF, 0));
      drive_inputs();
      tick();
      pulse_reset("rst_pend");
      repeat (100) tick();
      pulse_reset("rst_scrub");
      while (scrub_left > 0) tick();

      for (int i = 0; i < 32; i++) begin
         q1.push_back(mk(1, 0, i, 4'hF, 0));
         q0.push_back(mk(1, 0, $urandom_range(0, NUM_WORDS - 1), 4'hF, 0));
      end
      drain(200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
